// File: rtl/regfile_pkg.sv
// Register file geometry shared by the read arbiter and its users.
package regfile_pkg;

  localparam int REG_COUNT      = 8;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int REG_DATA_WIDTH = 32;

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester/register-file side bundle of the shared read port.
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int ID_WIDTH   = 2
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            gnt;
  logic [ADDR_WIDTH-1:0]         rf_addr;
  logic [DATA_WIDTH-1:0]         rf_data;
  logic                          rd_valid;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic [ID_WIDTH-1:0]           rd_id;

  // master is the environment: requesters plus the register file read mux
  modport master (
    output req, req_addr, rf_data,
    input  gnt, rf_addr, rd_valid, rd_data, rd_id
  );

  modport slave (
    input  req, req_addr, rf_data,
    output gnt, rf_addr, rd_valid, rd_data, rd_id
  );

endinterface

// File: rtl/regfile_read_arbiter_rr_priority_select.sv
// Combinational round-robin picker: first set bit of eligible at or after rr_ptr.
module rr_priority_select #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  eligible_i,
  input  logic [ID_WIDTH-1:0] rr_ptr_i,
  output logic                found_o,
  output logic [ID_WIDTH-1:0] winner_o
);

  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = int'(rr_ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found_o && eligible_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx[ID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter for the single register file read port: grant/address
// stage followed by a data capture stage, one read per cycle.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int ID_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_read_arbiter_if.slave  bus
);

  if (ID_WIDTH != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_cfg
    $error("regfile_read_arbiter: bad NUM_REQ/ID_WIDTH");
  end

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  s1_valid_q;
  logic [ID_WIDTH-1:0]   s1_id_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [ID_WIDTH-1:0]   rd_id_q;

  logic [NUM_REQ-1:0]    eligible;
  logic                  found;
  logic [ID_WIDTH-1:0]   winner;

  // Masking the current grant keeps a requester that drops req one cycle
  // after gnt from being picked a second time.
  assign eligible = bus.req & ~gnt_q;

  rr_priority_select #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .found_o    (found),
    .winner_o   (winner)
  );

  always_comb begin
    gnt_d     = '0;
    rf_addr_d = rf_addr_q;
    rr_ptr_d  = rr_ptr_q;
    if (found) begin
      gnt_d[winner] = 1'b1;
      // only the winner's address slice is read, so X elsewhere stays out
      rf_addr_d     = bus.req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      rr_ptr_d      = (int'(winner) == NUM_REQ-1) ? '0 : winner + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q      <= '0;
      rf_addr_q  <= '0;
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rf_addr_q  <= rf_addr_d;
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= found;
      if (found) s1_id_q <= winner;
      rd_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rd_data_q <= bus.rf_data;
        rd_id_q   <= s1_id_q;
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rf_addr  = rf_addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_id    = rd_id_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed cycle table plus a scoreboarded all-request burst for the read arbiter.
module tb_regfile_read_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] regs [8];

  always #5 clk = ~clk;

  regfile_read_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(3), .ID_WIDTH(2)) bus ();

  assign bus.rf_data = regs[bus.rf_addr];

  regfile_read_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(3), .ID_WIDTH(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] addr;
    logic [3:0]  gnt;
    logic [2:0]  rf_addr;
    logic        vld;
    logic [31:0] data;
    logic [1:0]  id;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] req,
                              input logic [2:0] a3, input logic [2:0] a2,
                              input logic [2:0] a1, input logic [2:0] a0,
                              input logic [3:0] g, input logic [2:0] rfa,
                              input logic v, input logic [31:0] d, input logic [1:0] id);
    vec_t r;
    r.rst = rst; r.req = req; r.addr = {a3, a2, a1, a0};
    r.gnt = g; r.rf_addr = rfa; r.vld = v; r.data = d; r.id = id;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t vecs [28];
  logic [2:0]  cur_addr [4];
  logic [2:0]  issued   [4];
  logic [31:0] exp_d  [$];
  logic [1:0]  exp_id [$];
  int          grants [4];

  initial begin
    regs[0] = 32'h0000_1000; regs[1] = 32'h1111_1111; regs[2] = 32'h2222_2222;
    regs[3] = 32'h3333_3333; regs[4] = 32'h4444_4444; regs[5] = 32'hDEAD_BEEF;
    regs[6] = 32'h6666_6666; regs[7] = 32'h7777_7777;

    //             rst req      a3 a2 a1 a0  gnt      rf vld data           id
    vecs[0]  = mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h0,          0);
    // single request to r5
    vecs[1]  = mk(0, 4'b0001, 0, 0, 0, 5, 4'b0001, 5, 0, 32'h0,          0);
    vecs[2]  = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 5, 1, 32'hDEAD_BEEF,  0);
    vecs[3]  = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 5, 0, 32'hDEAD_BEEF,  0);
    // all four from reset, each drops after its grant
    vecs[4]  = mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h0,          0);
    vecs[5]  = mk(0, 4'b1111, 4, 3, 2, 1, 4'b0001, 1, 0, 32'h0,          0);
    vecs[6]  = mk(0, 4'b1110, 4, 3, 2, 1, 4'b0010, 2, 1, 32'h1111_1111,  0);
    vecs[7]  = mk(0, 4'b1100, 4, 3, 2, 1, 4'b0100, 3, 1, 32'h2222_2222,  1);
    vecs[8]  = mk(0, 4'b1000, 4, 3, 2, 1, 4'b1000, 4, 1, 32'h3333_3333,  2);
    vecs[9]  = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4, 1, 32'h4444_4444,  3);
    vecs[10] = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4, 0, 32'h4444_4444,  3);
    // grant 1 -> ptr 2, then 1011 gives 3, 0, 1 (ptr wraps 3->0)
    vecs[11] = mk(0, 4'b0010, 0, 0, 6, 0, 4'b0010, 6, 0, 32'h4444_4444,  3);
    vecs[12] = mk(0, 4'b1011, 0, 0, 5, 7, 4'b1000, 0, 1, 32'h6666_6666,  1);
    vecs[13] = mk(0, 4'b0011, 0, 0, 5, 7, 4'b0001, 7, 1, 32'h0000_1000,  3);
    vecs[14] = mk(0, 4'b0010, 0, 0, 5, 7, 4'b0010, 5, 1, 32'h7777_7777,  0);
    vecs[15] = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 5, 1, 32'hDEAD_BEEF,  1);
    vecs[16] = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 5, 0, 32'hDEAD_BEEF,  1);
    // sole requester 2 holding req: every other cycle
    vecs[17] = mk(0, 4'b0100, 0, 2, 0, 0, 4'b0100, 2, 0, 32'hDEAD_BEEF,  1);
    vecs[18] = mk(0, 4'b0100, 0, 2, 0, 0, 4'b0000, 2, 1, 32'h2222_2222,  2);
    vecs[19] = mk(0, 4'b0100, 0, 2, 0, 0, 4'b0100, 2, 0, 32'h2222_2222,  2);
    vecs[20] = mk(0, 4'b0100, 0, 2, 0, 0, 4'b0000, 2, 1, 32'h2222_2222,  2);
    vecs[21] = mk(0, 4'b0100, 0, 2, 0, 0, 4'b0100, 2, 0, 32'h2222_2222,  2);
    // reset right after gnt=0100: nothing in flight survives, ptr back to 0
    vecs[22] = mk(1, 4'b0100, 0, 2, 0, 0, 4'b0000, 0, 0, 32'h0,          0);
    vecs[23] = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h0,          0);
    vecs[24] = mk(0, 4'b1001, 7, 0, 0, 3, 4'b0001, 3, 0, 32'h0,          0);
    vecs[25] = mk(0, 4'b1000, 7, 0, 0, 3, 4'b1000, 7, 1, 32'h3333_3333,  0);
    vecs[26] = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 7, 1, 32'h7777_7777,  3);
    vecs[27] = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 7, 0, 32'h7777_7777,  3);

    reset = 1'b1; bus.req = '0; bus.req_addr = '0;
    step();
    for (int k = 0; k < 28; k++) begin
      reset        = vecs[k].rst;
      bus.req      = vecs[k].req;
      bus.req_addr = vecs[k].addr;
      step();
      chk($sformatf("row%0d gnt", k),      bus.gnt,      vecs[k].gnt);
      chk($sformatf("row%0d rf_addr", k),  bus.rf_addr,  vecs[k].rf_addr);
      chk($sformatf("row%0d rd_valid", k), bus.rd_valid, vecs[k].vld);
      chk($sformatf("row%0d rd_data", k),  bus.rd_data,  vecs[k].data);
      chk($sformatf("row%0d rd_id", k),    bus.rd_id,    vecs[k].id);
    end

    // all requesters held for 40 cycles, random addresses and register contents
    for (int r = 0; r < 8; r++) regs[r] = $urandom;
    for (int i = 0; i < 4; i++) begin
      cur_addr[i] = 3'($urandom_range(0, 7));
      grants[i]   = 0;
    end
    reset = 1'b1; bus.req = '0;
    step();
    reset = 1'b0;
    for (int c = 0; c < 42; c++) begin
      bus.req = (c < 40) ? 4'b1111 : 4'b0000;
      bus.req_addr = {cur_addr[3], cur_addr[2], cur_addr[1], cur_addr[0]};
      for (int i = 0; i < 4; i++) issued[i] = cur_addr[i];
      step();
      for (int i = 0; i < 4; i++) grants[i] += int'(bus.gnt[i]);
      if (c < 40) begin
        int w;
        logic [3:0] oh;
        w  = c % 4;
        oh = 4'b0001 << w;
        chk($sformatf("burst c%0d gnt", c), bus.gnt, oh);
        chk($sformatf("burst c%0d rf_addr", c), bus.rf_addr, issued[w]);
        exp_d.push_back(regs[issued[w]]);
        exp_id.push_back(2'(w));
        cur_addr[w] = 3'($urandom_range(0, 7));
      end else begin
        chk($sformatf("burst c%0d gnt idle", c), bus.gnt, 4'b0000);
      end
      if (c >= 1 && c <= 40) begin
        logic [31:0] ed;
        logic [1:0]  ei;
        ed = exp_d.pop_front();
        ei = exp_id.pop_front();
        chk($sformatf("burst c%0d rd_valid", c), bus.rd_valid, 1'b1);
        chk($sformatf("burst c%0d rd_data", c), bus.rd_data, ed);
        chk($sformatf("burst c%0d rd_id", c), bus.rd_id, ei);
      end else begin
        chk($sformatf("burst c%0d rd_valid idle", c), bus.rd_valid, 1'b0);
      end
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("burst grants req%0d", i), grants[i], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
